// File: rtl/bin2bcd_display_formatter_pkg.sv
// Shared constants, types and the leading-zero helper for the binary-to-BCD display formatter.
// Define LEADING_ZERO_BLANK_EN to add the blank_mask output.
package display_pkg;

  localparam int DIGITS = 8;
  localparam int BIN_W  = 27;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(99_999_999);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  typedef logic [3:0] bcd_digit_t;

  // Bit i is set when digit i and every digit above it are zero. Digit 0 always shows.
  function automatic logic [DIGITS-1:0] leading_zero_mask(input logic [BCD_W-1:0] bcd);
    logic              all_zero;
    logic [DIGITS-1:0] mask;
    all_zero = 1'b1;
    mask     = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bin2bcd_display_formatter_if.sv
// Request/result bundle between the requestor and the BCD formatter.
// Define LEADING_ZERO_BLANK_EN to add the blank_mask signal.
interface bin2bcd_display_formatter_if;
  import display_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd_out;
  logic             overflow;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_mask;
`endif

  modport master (
    output start, bin_in,
`ifdef LEADING_ZERO_BLANK_EN
    input  blank_mask,
`endif
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
`ifdef LEADING_ZERO_BLANK_EN
    output blank_mask,
`endif
    output busy, done, bcd_out, overflow
  );

endinterface

// File: rtl/bin2bcd_display_formatter_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3
  import display_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_display_formatter.sv
// Sequential double-dabble converter: one input bit per clock, result held stable between conversions.
// Define LEADING_ZERO_BLANK_EN to register a leading-zero blank mask alongside bcd_out.
module bin2bcd_display_formatter
  import display_pkg::*;
(
  input  logic                            system_clock,
  input  logic                            cpu_rst_n,
  bin2bcd_display_formatter_if.slave      req
);

  bcd_state_t       state, next_state;
  logic [BIN_W-1:0] work;
  logic [BCD_W-1:0] acc, acc_adj;
  logic [CNT_W-1:0] count;
  logic             ovf_pending;
  logic             load, shift_en, finish;
  logic             done_q, overflow_q;
  logic [BCD_W-1:0] bcd_q;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (.din(acc[4*d +: 4]), .dout(acc_adj[4*d +: 4]));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state <= IDLE;
    else            state <= next_state;
  end

  // NOTE: default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req.start) next_state = SHIFT;
      SHIFT:   if (count == CNT_W'(BIN_W - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load     = (state == IDLE) && req.start;
    shift_en = (state == SHIFT);
    finish   = (state == DONE);
  end

  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      work        <= '0;
      acc         <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
    end else if (load) begin
      work        <= (req.bin_in > MAX_VAL) ? MAX_VAL : req.bin_in;
      ovf_pending <= (req.bin_in > MAX_VAL);
      acc         <= '0;
      count       <= '0;
    end else if (shift_en) begin
      {acc, work} <= {acc_adj[BCD_W-2:0], work, 1'b0};
      count       <= count + 1'b1;
    end
  end

  // Visible results move only on the DONE edge so the display never sees partial values.
  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        bcd_q      <= acc;
        overflow_q <= ovf_pending;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q;

  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n)  blank_q <= '0;
    else if (finish) blank_q <= leading_zero_mask(acc);
  end

  assign req.blank_mask = blank_q;
`endif

  assign req.busy     = (state != IDLE);
  assign req.done     = done_q;
  assign req.bcd_out  = bcd_q;
  assign req.overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_display_formatter.sv
// Directed-vector bench for bin2bcd_display_formatter; honours LEADING_ZERO_BLANK_EN when defined.
module tb_bin2bcd_display_formatter;
  import display_pkg::*;

  logic system_clock = 1'b0;
  logic cpu_rst_n;
  int   checks = 0;
  int   errors = 0;

  bin2bcd_display_formatter_if bus ();

  bin2bcd_display_formatter dut (
    .system_clock (system_clock),
    .cpu_rst_n    (cpu_rst_n),
    .req          (bus.slave)
  );

  always #5 system_clock = ~system_clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one conversion and follow it to done. Optionally drive a second start
  // (with a different bin_in) at sample index inj_idx to show it is ignored.
  task automatic convert(input string tag, input logic [BIN_W-1:0] val,
                         input logic [BCD_W-1:0] exp_bcd, input logic exp_ovf,
                         input logic [DIGITS-1:0] exp_mask,
                         input int inj_idx, input logic [BIN_W-1:0] inj_val);
    logic [BCD_W-1:0] prev_bcd;
    int busy_cnt = 0;
    int done_idx = 0;
    prev_bcd = bus.bcd_out;
    @(negedge system_clock);
    bus.start  = 1'b1;
    bus.bin_in = val;
    for (int idx = 1; idx <= 60 && done_idx == 0; idx++) begin
      @(negedge system_clock);
      bus.start = (idx == inj_idx);
      if (idx == inj_idx) bus.bin_in = inj_val;
      if (idx == 15) check({tag, "_held"}, bus.bcd_out, prev_bcd);
      if (bus.busy) busy_cnt++;
      if (bus.done) done_idx = idx;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, done_idx, 29);
    check({tag, "_busy_cycles"}, busy_cnt, 28);
    check({tag, "_bcd"}, bus.bcd_out, exp_bcd);
    check({tag, "_ovf"}, bus.overflow, exp_ovf);
`ifdef LEADING_ZERO_BLANK_EN
    check({tag, "_blank"}, bus.blank_mask, exp_mask);
`else
    if (exp_mask != exp_mask) $display("unused");
`endif
    @(negedge system_clock);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    int extra_done;
    cpu_rst_n  = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (2) @(negedge system_clock);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_bcd",  bus.bcd_out, 32'h0);
    check("rst_ovf",  bus.overflow, 1'b0);
    cpu_rst_n = 1'b1;
    @(negedge system_clock);

    convert("c12345678", 27'd12_345_678, 32'h12345678, 1'b0, 8'b00000000, 0, '0);
    convert("c0",        27'd0,          32'h00000000, 1'b0, 8'b11111110, 0, '0);
    convert("cmax",      27'd99_999_999, 32'h99999999, 1'b0, 8'b00000000, 0, '0);
    convert("csat",      27'h5F5E100,    32'h99999999, 1'b1, 8'b00000000, 0, '0);
    convert("c42",       27'd42,         32'h00000042, 1'b0, 8'b11111100, 0, '0);
    convert("c305",      27'd305,        32'h00000305, 1'b0, 8'b11111000, 0, '0);
    convert("c1234",     27'd1234,       32'h00001234, 1'b0, 8'b11110000, 6, 27'd9876);

    // The ignored second start must not produce a further done or change the result.
    extra_done = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge system_clock);
      if (bus.done) extra_done++;
    end
    check("ignored_start_done", extra_done, 0);
    check("ignored_start_bcd", bus.bcd_out, 32'h00001234);

    // Reset mid-conversion discards the result and clears the outputs.
    @(negedge system_clock);
    bus.start  = 1'b1;
    bus.bin_in = 27'd555;
    extra_done = 0;
    for (int idx = 1; idx <= 10; idx++) begin
      @(negedge system_clock);
      bus.start = 1'b0;
      if (bus.done) extra_done++;
    end
    cpu_rst_n = 1'b0;
    repeat (2) @(negedge system_clock);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_bcd",  bus.bcd_out, 32'h0);
    check("midrst_ovf",  bus.overflow, 1'b0);
    cpu_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge system_clock);
      if (bus.done) extra_done++;
    end
    check("midrst_no_done", extra_done, 0);
    check("midrst_idle", bus.busy, 1'b0);

    convert("c7", 27'd7, 32'h00000007, 1'b0, 8'b11111110, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_display_formatter.md
Name: bin2bcd_display_formatter

Overview:
Sequential double-dabble converter that turns a binary count into 8 packed BCD digits for the seven-segment display controller.
- Sits directly upstream of the display controller; its bcd_out drives the controller's value2disp input.
- Requestor (CPU-side logic or UART byte counter) issues a one-cycle start; the block iterates one bit per clock.
- Holds the last result stable so the multiplexed display never shows partial values.

Parameters:
DIGITS, 8, number of BCD digits produced (bcd_out width = 4*DIGITS)
BIN_W, 27, binary input width; iteration count = BIN_W (27 bits covers 99_999_999)

Ports:
system_clock  in  1  single clock for all logic
cpu_rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; accepted only in IDLE
bin_in  in  BIN_W  binary value; sampled only on the accepting edge
busy  out  1  high while a conversion is in flight
done  out  1  one-cycle pulse when bcd_out/overflow update
bcd_out  out  4*DIGITS  packed BCD, digit 7 at [31:28] (leftmost on display), digit 0 at [3:0]
overflow  out  1  bin_in exceeded 10^DIGITS-1 on the last conversion
blank_mask  out  DIGITS  only with LEADING_ZERO_BLANK_EN (see below)

Behaviour:
- Reset (async, cpu_rst_n=0): state=IDLE; busy=0, done=0, bcd_out=0, overflow=0, blank_mask=0, internal shift/count regs=0. Takes effect immediately, including mid-conversion; the in-flight result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k: load work reg with bin_in, saturating to 10^DIGITS-1 when bin_in is larger; latch ovf_pending = (bin_in > 10^DIGITS-1).
  - Clear BCD accumulator and count; go to SHIFT; busy=1 after edge k.
- SHIFT, one iteration per edge:
  - Add 3 to every BCD digit >= 5.
  - Shift {bcd, work} left by one, MSB of work entering bit 0 of bcd.
  - count increments; at count==BIN_W-1 go to DONE. Edges k+1..k+BIN_W.
- DONE, edge k+BIN_W+1:
  - bcd_out<=accumulator; overflow<=ovf_pending; done<=1 for exactly one cycle.
  - busy<=0; go to IDLE.
- Latency: done visible in the cycle after edge k+28 (default). Start accepted again from the next cycle.
- start in SHIFT or DONE is ignored, with no queuing. The requestor must wait for done or !busy.
- bcd_out and overflow change only on the DONE edge and stay stable otherwise.
- Every bcd_out nibble is always 0..9, so the downstream hex decoder never shows A-F.
- bin_in changes while busy have no effect.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - Port blank_mask[DIGITS-1:0] exists; bit i=1 means digit i is a leading zero and should be blanked downstream.
  - Computed from the final accumulator and registered on the DONE edge together with bcd_out.
  - Digit 0 is never blanked.
- Undefined: port and logic absent; every digit is always displayed.

Decomposition:
- Package display_pkg:
  - constants DIGITS, BIN_W, MAX_VAL (= 99_999_999);
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  - typedef logic [3:0] bcd_digit_t.
- Sub-module bcd_add3: combinational 4-bit digit correction (in>=5 ? in+3 : in), instantiated DIGITS times via generate.

Test Plan:
- Reset then start with bin_in=12_345_678 → busy high 28 cycles; done pulse after edge k+28; bcd_out=32'h12345678; overflow=0.
- bin_in=0, then bin_in=99_999_999 → bcd_out=32'h00000000, then 32'h99999999; overflow=0 both times.
- bin_in=100_000_000 (27'h5F5E100) → bcd_out=32'h99999999; overflow=1. Next conversion of 42 → bcd_out=32'h00000042; overflow=0.
- Start with 1234, then second start with 9876 at cycle k+5 → second ignored; bcd_out=32'h00001234; exactly one done pulse.
- Start with 555, assert cpu_rst_n=0 at cycle k+10 for 2 cycles → busy=0, bcd_out=0, no done. New start with 7 → bcd_out=32'h00000007.
- (LEADING_ZERO_BLANK_EN) bin_in=305 → bcd_out=32'h00000305, blank_mask=8'b11111000. bin_in=0 → blank_mask=8'b11111110.
